// File: rtl/rf_wport_arbiter_if.sv
// rtl/rf_wport_arbiter_if.sv - WB / mul-div / hazard-query / RF write-port bundle for rf_wport_arbiter
interface rf_wport_arbiter_if #(
  parameter int MD_FIFO_DEPTH = 2
);
  logic                             wb_valid;
  logic                             wb_ready;
  logic [4:0]                       wb_dest;
  logic [31:0]                      wb_data;
  logic                             md_valid;
  logic                             md_ready;
  logic [4:0]                       md_dest;
  logic [31:0]                      md_data;
  logic [4:0]                       q_addr;
  logic                             q_pending;
  logic                             rf_we;
  logic [4:0]                       rf_waddr;
  logic [31:0]                      rf_wdata;
  logic [$clog2(MD_FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  wb_valid, wb_dest, wb_data, md_valid, md_dest, md_data, q_addr,
    output wb_ready, md_ready, q_pending, rf_we, rf_waddr, rf_wdata, fifo_count
  );

  modport master (
    output wb_valid, wb_dest, wb_data, md_valid, md_dest, md_data, q_addr,
    input  wb_ready, md_ready, q_pending, rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - RF write-port arbiter: WB priority, buffered mul/div results, pending query
// Optional starvation guard for mul/div enabled by defining RF_ARB_STARVE_GUARD_EN.
module rf_wport_arbiter #(
  parameter int MD_FIFO_DEPTH = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic               clk,
  input  logic               reset,
  rf_wport_arbiter_if.slave  bus
);
  localparam int AW = $clog2(MD_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(MD_FIFO_DEPTH);

  if (MD_FIFO_DEPTH < 2 || (MD_FIFO_DEPTH & (MD_FIFO_DEPTH - 1)) != 0 ||
      STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
    $error("rf_wport_arbiter: illegal MD_FIFO_DEPTH or STARVE_MAX");
  end

  logic [4:0]    dest_q [MD_FIFO_DEPTH];
  logic [31:0]   data_q [MD_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          fifo_empty, push, wb_ready, grant_wb, grant_md, q_pending;

`ifdef RF_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  logic       force_md;

  // Once mul/div has lost STARVE_MAX times in a row, WB is held off for one cycle.
  assign force_md = !fifo_empty && (starve_q == 3'(STARVE_MAX));
  assign wb_ready = !force_md;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_md) starve_d = 3'd0;
    else if (grant_wb)          starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= 3'd0;
    else       starve_q <= starve_d;
  end
`else
  assign wb_ready = 1'b1;
`endif

  assign fifo_empty = (count_q == '0);
  // Readiness looks only at the registered count, so a full FIFO refuses even while popping.
  assign push       = bus.md_valid && (count_q != FULL);
  assign grant_wb   = bus.wb_valid && wb_ready;
  assign grant_md   = !fifo_empty && !grant_wb;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (push)     wr_ptr_d = wr_ptr_q + AW'(1);
    if (grant_md) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !grant_md)      count_d = count_q + CW'(1);
    else if (!push && grant_md) count_d = count_q - CW'(1);
    if (grant_wb) begin
      rf_we_d    = (bus.wb_dest != 5'd0);
      rf_waddr_d = bus.wb_dest;
      rf_wdata_d = bus.wb_data;
    end else if (grant_md) begin
      rf_we_d    = (dest_q[rd_ptr_q] != 5'd0);
      rf_waddr_d = dest_q[rd_ptr_q];
      rf_wdata_d = data_q[rd_ptr_q];
    end
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] off;
    off       = '0;
    q_pending = 1'b0;
    for (int i = 0; i < MD_FIFO_DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (dest_q[i] == bus.q_addr)) q_pending = 1'b1;
    end
    if (bus.q_addr == 5'd0) q_pending = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= bus.md_dest;
      data_q[wr_ptr_q] <= bus.md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.wb_ready   = wb_ready;
  assign bus.md_ready   = (count_q != FULL);
  assign bus.q_pending  = q_pending;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_count = count_q;
endmodule
